sdram_line_fill: RTL and testbench

- Port-B writer for the 256x32 cache data RAM.
- Accepts a line-fill request, then consumes 16-bit SDRAM read-burst beats.
- Packs each beat pair into a 32-bit word and writes the words into the RAM in critical-word-first wrapped order.
- Sits between the SDRAM read datapath and the cache data store; port A of the RAM stays free for CPU reads.

---
 rtl/sdram_cache_pkg.sv | 21 ++
 rtl/sdram_line_fill_if.sv | 36 +++
 rtl/sdram_line_fill.sv | 151 +++++++++++++++
 tb/tb_sdram_line_fill.sv | 336 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sdram_cache_pkg.sv
// Shared definitions for the SDRAM-to-cache line-fill path: FSM state encoding,
// default bus widths and the line-offset width helper.
package sdram_cache_pkg;

  localparam int ADDR_W_DEF     = 8;
  localparam int BEAT_W_DEF     = 16;
  localparam int LINE_WORDS_DEF = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    HI   = 3'd1,
    LO   = 3'd2,
    WR   = 3'd3,
    FIN  = 3'd4
  } fill_state_e;

  function automatic int line_ofs_w(input int line_words);
    return $clog2(line_words);
  endfunction

endpackage

// File: rtl/sdram_line_fill_if.sv
// Request, SDRAM read-beat and RAM port-B signal bundle for sdram_line_fill.
// slave is the fill engine's view, master is the view of whoever drives it.
interface sdram_line_fill_if
  import sdram_cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int BEAT_W     = BEAT_W_DEF
) ();

  localparam int LINE_OFS_W = line_ofs_w(LINE_WORDS);

  logic                         req;
  logic [ADDR_W-LINE_OFS_W-1:0] req_line;
  logic [LINE_OFS_W-1:0]        req_word;
  logic                         busy;
  logic                         sd_valid;
  logic [BEAT_W-1:0]            sd_data;
  logic                         wren_b;
  logic [ADDR_W-1:0]            address_b;
  logic [2*BEAT_W-1:0]          data_b;
  logic                         done;
  logic                         crit_valid;
  logic [2*BEAT_W-1:0]          crit_data;

  modport slave (
    input  req, req_line, req_word, sd_valid, sd_data,
    output busy, wren_b, address_b, data_b, done, crit_valid, crit_data
  );

  modport master (
    output req, req_line, req_word, sd_valid, sd_data,
    input  busy, wren_b, address_b, data_b, done, crit_valid, crit_data
  );

endinterface

// File: rtl/sdram_line_fill.sv
// Cache line-fill writer: packs SDRAM beat pairs into words and writes them to RAM port B
// critical-word-first. Define SDRAM_LINE_FILL_CRIT_FWD_EN to forward the critical word.
module sdram_line_fill
  import sdram_cache_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int LINE_WORDS = LINE_WORDS_DEF,
  parameter int BEAT_W     = BEAT_W_DEF
) (
  input  logic             clock,
  input  logic             reset,
  sdram_line_fill_if.slave bus
);

  localparam int LINE_OFS_W = line_ofs_w(LINE_WORDS);
  localparam int LINE_W     = ADDR_W - LINE_OFS_W;
  localparam int WORD_W     = 2 * BEAT_W;
  localparam logic [LINE_OFS_W-1:0] LAST_CNT = LINE_OFS_W'(LINE_WORDS - 1);

  fill_state_e             state_q, state_d;
  logic [LINE_W-1:0]       line_q, line_d;
  logic [LINE_OFS_W-1:0]   word_q, word_d;
  logic [LINE_OFS_W-1:0]   cnt_q, cnt_d;
  logic [LINE_OFS_W-1:0]   ofs;
  logic [BEAT_W-1:0]       hi_q, hi_d;
  logic                    wren_q, wren_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [WORD_W-1:0]       data_q, data_d;
  logic                    busy;
  logic                    done;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      line_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      hi_q    <= '0;
      wren_q  <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      line_q  <= line_d;
      word_q  <= word_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      wren_q  <= wren_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // A beat seen during a non-final WR opens the next word, so WR can skip straight to LO.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.req) state_d = HI;
      HI:   if (bus.sd_valid) state_d = LO;
      LO:   if (bus.sd_valid) state_d = WR;
      WR: begin
        if (cnt_q == LAST_CNT)  state_d = FIN;
        else if (bus.sd_valid)  state_d = LO;
        else                    state_d = HI;
      end
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    line_d = line_q;
    word_d = word_q;
    cnt_d  = cnt_q;
    hi_d   = hi_q;
    wren_d = 1'b0;
    addr_d = addr_q;
    data_d = data_q;
    ofs    = word_q + cnt_q;
    case (state_q)
      IDLE: begin
        if (bus.req) begin
          line_d = bus.req_line;
          word_d = bus.req_word;
          cnt_d  = '0;
        end
      end
      HI: if (bus.sd_valid) hi_d = bus.sd_data;
      LO: begin
        if (bus.sd_valid) begin
          wren_d = 1'b1;
          addr_d = {line_q, ofs};
          data_d = {hi_q, bus.sd_data};
        end
      end
      WR: begin
        cnt_d = cnt_q + LINE_OFS_W'(1);
        if (cnt_q != LAST_CNT && bus.sd_valid) hi_d = bus.sd_data;
      end
      default: ;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      HI, LO, WR: busy = 1'b1;
      FIN:        done = 1'b1;
      default:    ;
    endcase
  end

  assign bus.busy      = busy;
  assign bus.done      = done;
  assign bus.wren_b    = wren_q;
  assign bus.address_b = addr_q;
  assign bus.data_b    = data_q;

`ifdef SDRAM_LINE_FILL_CRIT_FWD_EN
  logic              crit_valid_q, crit_valid_d;
  logic [WORD_W-1:0] crit_data_q, crit_data_d;

  // The first word of every fill is the critical one, whatever its offset in the line.
  always_comb begin
    crit_valid_d = 1'b0;
    crit_data_d  = crit_data_q;
    if (state_q == LO && bus.sd_valid && cnt_q == '0) begin
      crit_valid_d = 1'b1;
      crit_data_d  = {hi_q, bus.sd_data};
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      crit_valid_q <= 1'b0;
      crit_data_q  <= '0;
    end else begin
      crit_valid_q <= crit_valid_d;
      crit_data_q  <= crit_data_d;
    end
  end

  assign bus.crit_valid = crit_valid_q;
  assign bus.crit_data  = crit_data_q;
`else
  assign bus.crit_valid = 1'b0;
  assign bus.crit_data  = '0;
`endif

endmodule

// File: tb/tb_sdram_line_fill.sv
// Self-checking bench for sdram_line_fill: directed fills from the test plan plus random
// traffic, all checked every cycle against a beat-counting reference model.
module tb_sdram_line_fill;

  localparam int ADDR_W = 8;
  localparam int LW     = 4;
  localparam int BEAT_W = 16;
`ifdef SDRAM_LINE_FILL_CRIT_FWD_EN
  localparam bit CRIT_EN = 1'b1;
`else
  localparam bit CRIT_EN = 1'b0;
`endif

  typedef enum int {M_IDLE, M_FILL, M_LASTWR, M_FIN} mphase_e;

  logic clock;
  logic reset;

  sdram_line_fill_if #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .BEAT_W(BEAT_W)) bus ();

  sdram_line_fill #(.ADDR_W(ADDR_W), .LINE_WORDS(LW), .BEAT_W(BEAT_W)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  int assertions = 0;
  int failures   = 0;

  mphase_e      m_phase;
  int           m_beats;
  int           m_line;
  int           m_word;
  logic [15:0]  m_prev;
  logic         exp_wren, exp_crit_valid;
  logic [7:0]   exp_addr;
  logic [31:0]  exp_data, exp_crit_data;

  logic [7:0]   wr_addr[$];
  logic [31:0]  wr_data[$];
  logic [31:0]  ram[256];
  int           done_cnt = 0;
  int           consec_wren = 0;
  int           cycle = 0;
  int           last_wr_cycle = 0;
  int           done_cycle = 0;
  int           crit_cnt = 0;
  logic [31:0]  crit_seen_data;
  logic [7:0]   crit_seen_addr;
  logic         crit_seen_wren;
  logic         prev_wren = 1'b0;

  logic [31:0]  basic_data[4] = '{32'h11112222, 32'h33334444, 32'h55556666, 32'h77778888};
  logic [7:0]   wrap_addr[4]  = '{8'hFF, 8'hFC, 8'hFD, 8'hFE};
  logic [7:0]   crit_addr[4]  = '{8'h16, 8'h17, 8'h14, 8'h15};
  logic [7:0]   refill_addr[4] = '{8'h26, 8'h27, 8'h24, 8'h25};

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    assertions++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s at cycle %0d: got 0x%0h, expected 0x%0h", name, cycle, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Reference model: a fill accepts beats until 2*LW have arrived; every second beat
  // produces one write on the following cycle, then one busy write cycle and one done cycle.
  initial begin
    m_phase = M_IDLE;
    forever begin
      @(posedge clock);
      cycle++;
      if (reset) begin
        m_phase        = M_IDLE;
        m_beats        = 0;
        exp_wren       = 1'b0;
        exp_addr       = '0;
        exp_data       = '0;
        exp_crit_valid = 1'b0;
        exp_crit_data  = '0;
      end else begin
        exp_wren       = 1'b0;
        exp_crit_valid = 1'b0;
        case (m_phase)
          M_IDLE: begin
            if (bus.req) begin
              m_phase = M_FILL;
              m_beats = 0;
              m_line  = int'(bus.req_line);
              m_word  = int'(bus.req_word);
            end
          end
          M_FILL: begin
            if (bus.sd_valid) begin
              m_beats++;
              if (m_beats % 2 == 1) begin
                m_prev = bus.sd_data;
              end else begin
                exp_wren = 1'b1;
                exp_addr = 8'(m_line * LW + (m_word + m_beats / 2 - 1) % LW);
                exp_data = {m_prev, bus.sd_data};
                if (CRIT_EN && m_beats == 2) begin
                  exp_crit_valid = 1'b1;
                  exp_crit_data  = exp_data;
                end
                if (m_beats == 2 * LW) m_phase = M_LASTWR;
              end
            end
          end
          M_LASTWR: m_phase = M_FIN;
          default:  m_phase = M_IDLE;
        endcase
      end
    end
  end

  // Compare process: every cycle from the first clock edge onwards.
  initial begin
    @(posedge clock);
    forever begin
      @(negedge clock);
      checkOutput("busy", 32'(bus.busy), 32'(m_phase == M_FILL || m_phase == M_LASTWR));
      checkOutput("done", 32'(bus.done), 32'(m_phase == M_FIN));
      checkOutput("wren_b", 32'(bus.wren_b), 32'(exp_wren));
      checkOutput("address_b", 32'(bus.address_b), 32'(exp_addr));
      checkOutput("data_b", bus.data_b, exp_data);
      checkOutput("crit_valid", 32'(bus.crit_valid), 32'(exp_crit_valid));
      checkOutput("crit_data", bus.crit_data, exp_crit_data);
      if (bus.wren_b === 1'b1) begin
        wr_addr.push_back(bus.address_b);
        wr_data.push_back(bus.data_b);
        ram[bus.address_b] = bus.data_b;
        last_wr_cycle = cycle;
        if (prev_wren) consec_wren++;
      end
      prev_wren = (bus.wren_b === 1'b1);
      if (bus.done === 1'b1) begin
        done_cnt++;
        done_cycle = cycle;
      end
      if (bus.crit_valid === 1'b1) begin
        crit_cnt++;
        crit_seen_data = bus.crit_data;
        crit_seen_addr = bus.address_b;
        crit_seen_wren = bus.wren_b;
      end
    end
  end

  task automatic applyStimulus(input int line, input int word, input int gap, input bit req_noise);
    bus.req      = 1'b1;
    bus.req_line = 6'(line);
    bus.req_word = 2'(word);
    tick();
    bus.req = 1'b0;
    for (int b = 0; b < 2 * LW; b++) begin
      bus.sd_valid = 1'b1;
      bus.sd_data  = 16'(16'h1111 * (b + 1));
      if (req_noise) begin
        bus.req      = 1'(b % 2);
        bus.req_line = 6'(line ^ 1);
        bus.req_word = 2'(word + 1);
      end
      tick();
      bus.sd_valid = 1'b0;
      bus.req      = 1'b0;
      for (int g = 0; g < gap; g++) tick();
    end
  endtask

  task automatic wait_done(input int start_cnt, input int budget);
    int n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      tick();
      n++;
    end
    checkOutput("done_seen", 32'(done_cnt != start_cnt), 32'd1);
    tick();
  endtask

  task automatic clear_log();
    wr_addr.delete();
    wr_data.delete();
  endtask

  task automatic check_line(input string name, input logic [7:0] addrs[4]);
    checkOutput({name, "_count"}, 32'(wr_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) begin
      if (i < wr_addr.size()) begin
        checkOutput({name, "_addr"}, 32'(wr_addr[i]), 32'(addrs[i]));
        checkOutput({name, "_data"}, wr_data[i], basic_data[i]);
      end
    end
  endtask

  initial begin
    int d0;
    int n;
    logic [7:0] a_basic[4];
    for (int i = 0; i < 4; i++) a_basic[i] = 8'(8'h14 + i);

    reset        = 1'b1;
    bus.req      = 1'b0;
    bus.req_line = '0;
    bus.req_word = '0;
    bus.sd_valid = 1'b0;
    bus.sd_data  = '0;
    repeat (3) tick();
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_wren", 32'(bus.wren_b), 32'd0);
    checkOutput("reset_addr", 32'(bus.address_b), 32'd0);
    checkOutput("reset_data", bus.data_b, 32'd0);
    reset = 1'b0;
    tick();

    $display("[TB] basic fill");
    clear_log();
    d0 = done_cnt;
    applyStimulus(5, 0, 0, 1'b0);
    wait_done(d0, 20);
    check_line("basic", a_basic);
    checkOutput("basic_done_latency", 32'(done_cycle - last_wr_cycle), 32'd1);

    $display("[TB] wrapped fill");
    clear_log();
    d0 = done_cnt;
    applyStimulus(8'h3F, 3, 0, 1'b0);
    wait_done(d0, 20);
    check_line("wrap", wrap_addr);

    $display("[TB] gapped fill");
    clear_log();
    for (int i = 0; i < 4; i++) ram[8'h14 + i] = '0;
    d0 = done_cnt;
    applyStimulus(5, 0, 3, 1'b0);
    wait_done(d0, 60);
    checkOutput("gap_count", 32'(wr_addr.size()), 32'd4);
    for (int i = 0; i < 4; i++) checkOutput("gap_ram", ram[8'h14 + i], basic_data[i]);
    checkOutput("gap_consec_wren", 32'(consec_wren), 32'd0);

    $display("[TB] reset mid-fill");
    clear_log();
    d0 = done_cnt;
    bus.req = 1'b1; bus.req_line = 6'd2; bus.req_word = 2'd1;
    tick();
    bus.req = 1'b0;
    for (int b = 0; b < 4; b++) begin
      bus.sd_valid = 1'b1;
      bus.sd_data  = 16'(16'hA000 + b);
      tick();
    end
    bus.sd_valid = 1'b0;
    n = 0;
    while (wr_addr.size() < 2 && n < 20) begin
      tick();
      n++;
    end
    checkOutput("midreset_two_writes", 32'(wr_addr.size()), 32'd2);
    reset = 1'b1;
    tick();
    checkOutput("midreset_busy", 32'(bus.busy), 32'd0);
    checkOutput("midreset_wren", 32'(bus.wren_b), 32'd0);
    reset = 1'b0;
    repeat (4) tick();
    checkOutput("midreset_no_done", 32'(done_cnt - d0), 32'd0);
    clear_log();
    applyStimulus(9, 2, 0, 1'b0);
    wait_done(d0, 20);
    check_line("refill", refill_addr);

    $display("[TB] ignored inputs");
    clear_log();
    bus.sd_valid = 1'b1;
    bus.sd_data  = 16'hDEAD;
    repeat (3) tick();
    bus.sd_valid = 1'b0;
    checkOutput("idle_beats_busy", 32'(bus.busy), 32'd0);
    checkOutput("idle_beats_writes", 32'(wr_addr.size()), 32'd0);
    d0 = done_cnt;
    applyStimulus(5, 0, 1, 1'b1);
    wait_done(d0, 40);
    repeat (3) tick();
    check_line("noisy", a_basic);

    $display("[TB] critical word fill");
    clear_log();
    d0 = crit_cnt;
    applyStimulus(5, 2, 0, 1'b0);
    wait_done(done_cnt - 0 == 0 ? 0 : done_cnt, 20);
    check_line("crit", crit_addr);
`ifdef SDRAM_LINE_FILL_CRIT_FWD_EN
    checkOutput("crit_pulses", 32'(crit_cnt - d0), 32'd1);
    checkOutput("crit_data_lit", crit_seen_data, 32'h11112222);
    checkOutput("crit_with_wren", 32'(crit_seen_wren), 32'd1);
    checkOutput("crit_addr_lit", 32'(crit_seen_addr), 32'h16);
`else
    checkOutput("crit_pulses", 32'(crit_cnt - d0), 32'd0);
`endif

    $display("[TB] random traffic");
    for (int i = 0; i < 4000; i++) begin
      bus.req      = ($urandom_range(0, 9) == 0);
      bus.req_line = 6'($urandom);
      bus.req_word = 2'($urandom);
      bus.sd_valid = ($urandom_range(0, 3) != 0);
      bus.sd_data  = 16'($urandom);
      reset        = ($urandom_range(0, 499) == 0);
      tick();
    end
    reset        = 1'b0;
    bus.req      = 1'b0;
    bus.sd_valid = 1'b0;
    repeat (5) tick();
    checkOutput("random_consec_wren", 32'(consec_wren), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
